video_window_capture: RTL



---
 rtl/video_rx_pkg.sv | 25 ++
 rtl/sync_edge_detect.sv | 31 +++
 rtl/video_window_capture.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/video_rx_pkg.sv
// video_rx_pkg: shared FSM state type, measurement width and small helpers
// for the video window capture block.
package video_rx_pkg;

    localparam int MEAS_W = 12;

    typedef enum logic [1:0] {SEARCH, ARMED, LINE, HBLANK} vrx_state_e;

    // Bits needed to hold every value in 0..value, never less than one.
    function automatic int ceil_log2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) bits = ((value >> i) != 0) ? i + 1 : bits;
        return bits;
    endfunction

    function automatic int decim_shift(input int decim);
        return (decim == 4) ? 2 : (decim == 2) ? 1 : 0;
    endfunction

    function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] value);
        return (&value) ? value : value + MEAS_W'(1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registers vsync/active and flags their edges; edges are
// suppressed for the first cycle after reset so an idle-high vsync is not a toggle.
module sync_edge_detect (
    input  logic vid_clk,
    input  logic reset_n,
    input  logic vsync,
    input  logic active,
    output logic vs_toggle,
    output logic act_rise,
    output logic act_fall
);

    logic vs_q, act_q, primed_q;

    always_ff @(posedge vid_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q     <= 1'b0;
            act_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            vs_q     <= vsync;
            act_q    <= active;
            primed_q <= 1'b1;
        end
    end

    assign vs_toggle = primed_q & (vsync ^ vs_q);
    assign act_rise  = primed_q & active & ~act_q;
    assign act_fall  = primed_q & ~active & act_q;

endmodule

// File: rtl/video_window_capture.sv
// video_window_capture: crops and decimates a DE-framed video stream into a fixed
// window, and measures incoming frame geometry to decide lock.
module video_window_capture
    import video_rx_pkg::*;
#(
    parameter int H_RES_PIX      = 640,
    parameter int V_RES_PIX      = 480,
    parameter int H_START        = 0,
    parameter int V_START        = 0,
    parameter int H_DECIM        = 1,
    parameter int V_DECIM        = 1,
    parameter int BITS_PER_PIXEL = 24,
    parameter int LOCK_FRAMES    = 2,
    localparam int HW = ceil_log2(H_RES_PIX / H_DECIM - 1),
    localparam int VW = ceil_log2(V_RES_PIX / V_DECIM - 1)
) (
    input  logic                      vid_clk,
    input  logic                      reset_n,
    input  logic                      vsync,
    input  logic                      active,
    input  logic [BITS_PER_PIXEL-1:0] pixel_in,
    output logic                      data_en,
    output logic [BITS_PER_PIXEL-1:0] pixel_out,
    output logic [HW-1:0]             h_pos,
    output logic [VW-1:0]             v_pos,
    output logic                      line_ready,
    output logic                      frame_ready,
    output logic [MEAS_W-1:0]         meas_width,
    output logic [MEAS_W-1:0]         meas_height,
    output logic                      locked,
    output logic [15:0]               frame_cnt
);

    localparam int LW = ceil_log2(LOCK_FRAMES);
    localparam int H_SH = decim_shift(H_DECIM);
    localparam int V_SH = decim_shift(V_DECIM);
    localparam logic [MEAS_W-1:0] H_START_C = MEAS_W'(H_START);
    localparam logic [MEAS_W-1:0] V_START_C = MEAS_W'(V_START);
    localparam logic [MEAS_W-1:0] H_RES_C   = MEAS_W'(H_RES_PIX);
    localparam logic [MEAS_W-1:0] V_RES_C   = MEAS_W'(V_RES_PIX);
    localparam logic [MEAS_W-1:0] H_END_C   = MEAS_W'(H_START + H_RES_PIX);
    localparam logic [MEAS_W-1:0] V_END_C   = MEAS_W'(V_START + V_RES_PIX);
    localparam logic [MEAS_W-1:0] H_MASK    = MEAS_W'(H_DECIM - 1);
    localparam logic [MEAS_W-1:0] V_MASK    = MEAS_W'(V_DECIM - 1);
    localparam logic [HW-1:0]     LAST_COL  = HW'(H_RES_PIX / H_DECIM - 1);
    localparam logic [VW-1:0]     LAST_ROW  = VW'(V_RES_PIX / V_DECIM - 1);
    localparam logic [LW-1:0]     LOCK_C    = LW'(LOCK_FRAMES);

    vrx_state_e state_q, state_d, state_eff;
    logic vs_toggle, act_rise, act_fall;
    logic [MEAS_W-1:0] pix_cnt_q, pix_cnt_d, line_q, line_d;
    logic [MEAS_W-1:0] pix_idx, hx, vy, meas_h_d;
    logic pix_vld, win, load, good;
    logic data_en_q, line_ready_q, frame_ready_q, locked_q;
    logic [BITS_PER_PIXEL-1:0] pixel_q;
    logic [HW-1:0] h_pos_q;
    logic [VW-1:0] v_pos_q;
    logic [MEAS_W-1:0] meas_w_q, meas_h_q;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [15:0] frame_cnt_q;

    sync_edge_detect u_edge (
        .vid_clk   (vid_clk),
        .reset_n   (reset_n),
        .vsync     (vsync),
        .active    (active),
        .vs_toggle (vs_toggle),
        .act_rise  (act_rise),
        .act_fall  (act_fall)
    );

    // A toggle is applied before any active edge seen in the same cycle.
    always_comb begin
        state_eff = vs_toggle ? ARMED : state_q;
        state_d   = state_eff;
        pix_cnt_d = pix_cnt_q;
        line_d    = line_q;
        pix_vld   = 1'b0;
        if (act_rise && (state_eff == ARMED || state_eff == HBLANK)) begin
            state_d   = LINE;
            pix_cnt_d = MEAS_W'(1);
            line_d    = (state_eff == ARMED) ? '0 : sat_inc(line_q);
            pix_vld   = 1'b1;
        end else if (state_eff == LINE && act_fall) begin
            state_d = HBLANK;
        end else if (state_eff == LINE && active) begin
            pix_cnt_d = sat_inc(pix_cnt_q);
            pix_vld   = 1'b1;
        end
    end

    // Offsets wrap below the start, so a single unsigned compare bounds both ends.
    assign pix_idx    = (state_eff == LINE) ? pix_cnt_q : '0;
    assign hx         = pix_idx - H_START_C;
    assign vy         = line_d - V_START_C;
    assign win        = pix_vld && (hx < H_RES_C) && (vy < V_RES_C) &&
                        ((hx & H_MASK) == '0) && ((vy & V_MASK) == '0);
    assign load       = vs_toggle && (state_q == LINE || state_q == HBLANK);
    assign meas_h_d   = sat_inc(line_q);
    assign good       = (pix_cnt_q >= H_END_C) && (meas_h_d >= V_END_C);
    assign lock_cnt_d = !good ? '0 : (lock_cnt_q == LOCK_C) ? lock_cnt_q : lock_cnt_q + LW'(1);

    always_ff @(posedge vid_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SEARCH;
            pix_cnt_q     <= '0;
            line_q        <= '0;
            data_en_q     <= 1'b0;
            pixel_q       <= '0;
            h_pos_q       <= '0;
            v_pos_q       <= '0;
            line_ready_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            meas_w_q      <= '0;
            meas_h_q      <= '0;
            lock_cnt_q    <= '0;
            locked_q      <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            line_q        <= line_d;
            data_en_q     <= win;
            if (win) begin
                pixel_q <= pixel_in;
                h_pos_q <= HW'(hx >> H_SH);
                v_pos_q <= VW'(vy >> V_SH);
            end
            line_ready_q  <= data_en_q && (h_pos_q == LAST_COL);
            frame_ready_q <= data_en_q && (h_pos_q == LAST_COL) && (v_pos_q == LAST_ROW);
            if (load) begin
                meas_w_q    <= pix_cnt_q;
                meas_h_q    <= meas_h_d;
                lock_cnt_q  <= lock_cnt_d;
                locked_q    <= (lock_cnt_d == LOCK_C);
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign data_en     = data_en_q;
    assign pixel_out   = pixel_q;
    assign h_pos       = h_pos_q;
    assign v_pos       = v_pos_q;
    assign line_ready  = line_ready_q;
    assign frame_ready = frame_ready_q;
    assign meas_width  = meas_w_q;
    assign meas_height = meas_h_q;
    assign locked      = locked_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
